region_mean_acc: RTL

REGION_MEAN_ACC -- requirements
Module: region_mean_acc

---
 rtl/region_mean_acc.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/region_mean_acc.sv
// rtl/region_mean_acc.sv - per-window RGB region accumulator driving a shared divider for channel means
//
// Purpose:
//   Accumulates the R/G/B sums and the pixel count of qualifying region pixels
//   between frame_start and frame_end. It then runs three sequential divisions
//   on an external divider, in the order R, G, B, and publishes the three means
//   together with a one-cycle mean_valid pulse.
//
// Ports:
//   clk, rst                   rising-edge clock, synchronous active-high reset
//   frame_start, frame_end     window open / close pulses
//   pix_valid, pix_in_region   pixel qualifiers (both high = accumulate)
//   pix_r, pix_g, pix_b        pixel channels, PIX_W bits each
//   div_en, div_a, div_b       divider request pulse, dividend (channel sum), divisor (count)
//   div_done, div_q            divider completion (held >= 2 cycles), quotient
//   mean_r, mean_g, mean_b     published region means, stable between mean_valid pulses
//   mean_valid                 one-cycle pulse when the means update
//   region_empty               last window had no region pixels
//   busy                       high whenever the block is not idle

module region_mean_acc #(
  parameter int PIX_W = 8,
  parameter int SUM_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             frame_end,
  input  logic             pix_valid,
  input  logic             pix_in_region,
  input  logic [PIX_W-1:0] pix_r,
  input  logic [PIX_W-1:0] pix_g,
  input  logic [PIX_W-1:0] pix_b,
  output logic             div_en,
  output logic [SUM_W-1:0] div_a,
  output logic [SUM_W-1:0] div_b,
  input  logic             div_done,
  input  logic [SUM_W-1:0] div_q,
  output logic [PIX_W-1:0] mean_r,
  output logic [PIX_W-1:0] mean_g,
  output logic [PIX_W-1:0] mean_b,
  output logic             mean_valid,
  output logic             region_empty,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC,
    S_ISSUE,
    S_WAIT,
    S_RELEASE,
    S_OUT
  } state_t;

  localparam logic [SUM_W-1:0] CNT_ONE = {{(SUM_W-1){1'b0}}, 1'b1};

  state_t state;
  state_t state_nxt;

  logic [SUM_W-1:0] sum_r;
  logic [SUM_W-1:0] sum_g;
  logic [SUM_W-1:0] sum_b;
  logic [SUM_W-1:0] count;
  logic [SUM_W-1:0] sum_r_nxt;
  logic [SUM_W-1:0] sum_g_nxt;
  logic [SUM_W-1:0] sum_b_nxt;
  logic [SUM_W-1:0] count_nxt;
  logic [SUM_W-1:0] base_r;
  logic [SUM_W-1:0] base_g;
  logic [SUM_W-1:0] base_b;
  logic [SUM_W-1:0] base_cnt;

  logic [1:0]       ch;
  logic             done_prev;
  logic             done_rise;
  logic [PIX_W-1:0] q_sat;
  logic [PIX_W-1:0] shadow_r;
  logic [PIX_W-1:0] shadow_g;
  logic [PIX_W-1:0] shadow_b;

  logic hit;
  logic win_open;
  logic acc_en;

  // Add a pixel channel to a running sum, sticking at all-ones instead of wrapping.
  function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] s,
                                               input logic [PIX_W-1:0] p);
    logic [SUM_W:0] t;
    t = {1'b0, s} + {{(SUM_W+1-PIX_W){1'b0}}, p};
    return t[SUM_W] ? {SUM_W{1'b1}} : t[SUM_W-1:0];
  endfunction

  assign hit      = pix_valid & pix_in_region;
  // A frame_start in ACC restarts the window exactly like one in IDLE.
  assign win_open = frame_start & ((state == S_IDLE) | (state == S_ACC));
  assign acc_en   = win_open | (state == S_ACC);

  assign done_rise = div_done & ~done_prev;
  assign q_sat     = (div_q[SUM_W-1:PIX_W] != '0) ? {PIX_W{1'b1}} : div_q[PIX_W-1:0];

  assign busy  = (state != S_IDLE);
  assign div_b = count;

  // Sums are frozen outside ACC, so the operand mux stays stable until the
  // matching result is accepted; it only moves when the channel index advances.
  always_comb begin
    div_a = sum_b;
    case (ch)
      2'd0:    div_a = sum_r;
      2'd1:    div_a = sum_g;
      default: div_a = sum_b;
    endcase
  end

  // Next accumulator values, including the pixel presented on the same cycle
  // as frame_start (after clearing) or frame_end.
  always_comb begin
    base_r    = win_open ? '0 : sum_r;
    base_g    = win_open ? '0 : sum_g;
    base_b    = win_open ? '0 : sum_b;
    base_cnt  = win_open ? '0 : count;
    sum_r_nxt = base_r;
    sum_g_nxt = base_g;
    sum_b_nxt = base_b;
    count_nxt = base_cnt;
    if (hit) begin
      sum_r_nxt = sat_add(base_r, pix_r);
      sum_g_nxt = sat_add(base_g, pix_g);
      sum_b_nxt = sat_add(base_b, pix_b);
      count_nxt = (base_cnt == {SUM_W{1'b1}}) ? base_cnt : base_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    div_en    = 1'b0;
    case (state)
      S_IDLE: begin
        if (frame_start) begin
          state_nxt = S_ACC;
        end
      end
      S_ACC: begin
        // A restart on the same cycle keeps the window open.
        if (!frame_start && frame_end) begin
          state_nxt = (count_nxt != '0) ? S_ISSUE : S_OUT;
        end
      end
      S_ISSUE: begin
        // Hold off the request while the divider still shows a done level.
        if (!div_done) begin
          div_en    = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (done_rise) begin
          state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!div_done) begin
          state_nxt = (ch == 2'd2) ? S_OUT : S_ISSUE;
        end
      end
      S_OUT: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_r        <= '0;
      sum_g        <= '0;
      sum_b        <= '0;
      count        <= '0;
      ch           <= 2'd0;
      done_prev    <= 1'b0;
      shadow_r     <= '0;
      shadow_g     <= '0;
      shadow_b     <= '0;
      mean_r       <= '0;
      mean_g       <= '0;
      mean_b       <= '0;
      mean_valid   <= 1'b0;
      region_empty <= 1'b0;
    end else begin
      done_prev  <= div_done;
      mean_valid <= 1'b0;

      if (acc_en) begin
        sum_r <= sum_r_nxt;
        sum_g <= sum_g_nxt;
        sum_b <= sum_b_nxt;
        count <= count_nxt;
      end

      if (win_open) begin
        ch <= 2'd0;
      end

      case (state)
        S_WAIT: begin
          // Results land in shadow registers so the published means only
          // change together in OUT.
          if (done_rise) begin
            case (ch)
              2'd0:    shadow_r <= q_sat;
              2'd1:    shadow_g <= q_sat;
              default: shadow_b <= q_sat;
            endcase
          end
        end
        S_RELEASE: begin
          if (!div_done) begin
            ch <= (ch == 2'd2) ? 2'd0 : ch + 2'd1;
          end
        end
        S_OUT: begin
          mean_valid   <= 1'b1;
          region_empty <= (count == '0);
          if (count == '0) begin
            mean_r <= '0;
            mean_g <= '0;
            mean_b <= '0;
          end else begin
            mean_r <= shadow_r;
            mean_g <= shadow_g;
            mean_b <= shadow_b;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
